// File: rtl/mem_load_dump_ctrl_if.sv
// Bundle of the program-load stream, IMEM write port, CPU run/halt, DMEM read port
// and dump stream between mem_load_dump_ctrl (master) and its environment (slave).
interface mem_load_dump_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int IAW   = 9,
    parameter int DAW   = 9
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;

    logic             imem_we;
    logic [IAW-1:0]   imem_addr;
    logic [WIDTH-1:0] imem_wdata;
    logic             cpu_run;
    logic             cpu_halt;

    logic             dmem_re;
    logic [DAW-1:0]   dmem_addr;
    logic [WIDTH-1:0] dmem_rdata;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    logic             busy;
    logic             done;
    logic             timeout;

    modport master (
        input  start, in_valid, in_data, in_last, cpu_halt, dmem_rdata, out_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_run,
        output dmem_re, dmem_addr, out_valid, out_data, out_last, busy, done, timeout
    );

    modport slave (
        output start, in_valid, in_data, in_last, cpu_halt, dmem_rdata, out_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_run,
        input  dmem_re, dmem_addr, out_valid, out_data, out_last, busy, done, timeout
    );
endinterface

// File: rtl/mem_load_dump_ctrl.sv
// Loads a program stream into IMEM (padding the tail), runs the CPU until halt, then streams DMEM out.
// Define LOAD_DUMP_TIMEOUT_EN to add a RUN watchdog that forces the dump after MAX_CYCLES.
//
// state  | meaning
// S_IDLE | waiting for start
// S_LOAD | accepting program words into IMEM
// S_PAD  | filling remaining IMEM words with PAD_WORD
// S_RUN  | CPU running, waiting for cpu_halt (or watchdog)
// S_DUMP | reading DMEM 0..DMEM_DEPTH-1 onto the output stream
// S_DONE | dump complete, done held until next start
module mem_load_dump_ctrl #(
    parameter int               WIDTH      = 32,
    parameter int               IMEM_DEPTH = 512,
    parameter int               DMEM_DEPTH = 512,
    parameter logic [WIDTH-1:0] PAD_WORD   = 32'hFFFFFFFF,
    parameter int               MAX_CYCLES = 100000
) (
    input logic                  CLK,
    input logic                  RST_N,
    mem_load_dump_ctrl_if.master bus
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam logic [IAW-1:0] I_LAST = IAW'(IMEM_DEPTH - 1);
    localparam logic [DAW-1:0] D_LAST = DAW'(DMEM_DEPTH - 1);

    if (MAX_CYCLES < 1 || IMEM_DEPTH < 2 || DMEM_DEPTH < 2) begin : g_bad_cfg
        $error("mem_load_dump_ctrl: depths must be >= 2 and MAX_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PAD, S_RUN, S_DUMP, S_DONE
    } state_t;

    state_t           r_state;
    logic [IAW-1:0]   r_iaddr;
    logic             r_in_ready;
    logic             r_cpu_run;
    logic             r_busy;
    logic             r_done;
    logic [DAW-1:0]   r_raddr;
    logic             r_rd_done;
    logic             r_pend;
    logic             r_pend_last;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_last;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
`ifdef LOAD_DUMP_TIMEOUT_EN
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MAX_CYCLES - 1);
    logic [CW-1:0]    r_run_cnt;
    logic             r_timeout;
`endif

    logic       w_load_xfer;
    logic       w_pad_we;
    logic       w_consume;
    logic [1:0] w_occ;
    logic       w_issue;

    assign w_load_xfer = RST_N && (r_state == S_LOAD) && r_in_ready && bus.in_valid;
    assign w_pad_we    = RST_N && (r_state == S_PAD);
    assign w_consume   = r_out_valid && bus.out_ready;
    // Words held after this edge (output reg + skid + returning read); a new read
    // is issued only if its data is guaranteed a slot when it returns.
    assign w_occ       = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend} - {1'b0, w_consume};
    assign w_issue     = RST_N && (r_state == S_DUMP) && !r_rd_done && (w_occ <= 2'd1);

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = w_load_xfer || w_pad_we;
    assign bus.imem_addr  = r_iaddr;
    assign bus.imem_wdata = (r_state == S_LOAD) ? bus.in_data :
                            (r_state == S_PAD)  ? PAD_WORD : '0;
    assign bus.cpu_run    = r_cpu_run;
    assign bus.dmem_re    = w_issue;
    assign bus.dmem_addr  = r_raddr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
`ifdef LOAD_DUMP_TIMEOUT_EN
    assign bus.timeout    = r_timeout;
`else
    assign bus.timeout    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_iaddr      <= '0;
            r_in_ready   <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_raddr      <= '0;
            r_rd_done    <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
`ifdef LOAD_DUMP_TIMEOUT_EN
            r_run_cnt    <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state    <= S_LOAD;
                        r_iaddr    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_raddr    <= '0;
                        r_rd_done  <= 1'b0;
`ifdef LOAD_DUMP_TIMEOUT_EN
                        r_timeout  <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_load_xfer) begin
                        if (bus.in_last || (r_iaddr == I_LAST)) begin
                            r_in_ready <= 1'b0;
                            if (r_iaddr == I_LAST) begin
                                r_state   <= S_RUN;
                                r_cpu_run <= 1'b1;
`ifdef LOAD_DUMP_TIMEOUT_EN
                                r_run_cnt <= CNT_INIT;
`endif
                            end else begin
                                r_state <= S_PAD;
                                r_iaddr <= r_iaddr + 1'b1;
                            end
                        end else begin
                            r_iaddr <= r_iaddr + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (r_iaddr == I_LAST) begin
                        r_state   <= S_RUN;
                        r_cpu_run <= 1'b1;
`ifdef LOAD_DUMP_TIMEOUT_EN
                        r_run_cnt <= CNT_INIT;
`endif
                    end else begin
                        r_iaddr <= r_iaddr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.cpu_halt) begin
                        r_state   <= S_DUMP;
                        r_cpu_run <= 1'b0;
                    end
`ifdef LOAD_DUMP_TIMEOUT_EN
                    else if (r_run_cnt == '0) begin
                        r_state   <= S_DUMP;
                        r_cpu_run <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt - 1'b1;
                    end
`endif
                end
                S_DUMP: begin
                    if (w_issue) begin
                        r_pend      <= 1'b1;
                        r_pend_last <= (r_raddr == D_LAST);
                        if (r_raddr == D_LAST) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_raddr <= r_raddr + 1'b1;
                        end
                    end else begin
                        r_pend      <= 1'b0;
                        r_pend_last <= 1'b0;
                    end

                    // Output register refills from skid first so word order is preserved.
                    if (!r_out_valid || w_consume) begin
                        if (r_skid_valid) begin
                            r_out_valid  <= 1'b1;
                            r_out_data   <= r_skid_data;
                            r_out_last   <= r_skid_last;
                            r_skid_valid <= r_pend;
                            if (r_pend) begin
                                r_skid_data <= bus.dmem_rdata;
                                r_skid_last <= r_pend_last;
                            end
                        end else if (r_pend) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= bus.dmem_rdata;
                            r_out_last  <= r_pend_last;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end else if (r_pend) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= bus.dmem_rdata;
                        r_skid_last  <= r_pend_last;
                    end

                    if (w_consume && r_out_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
